conway_board_ctrl: RTL

//  Owns the WIDTH x HEIGHT board register on both ends of the combinational conway stepper.
//  - Drives the stepper's in_states and latches its out_states once per generation.
//  - Accepts a row-serial board load and steps N generations on command.
//  - Streams the resulting board back out row-serially.

---
 rtl/conway_board_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/conway_board_ctrl.sv
// Board register and sequencer around a combinational Conway stepper: row-serial load,
// N-generation run, row-serial dump. Optional still-life early stop: CONWAY_STILL_STOP_EN.
module conway_board_ctrl #(
   parameter int WIDTH  = 32,
   parameter int HEIGHT = 32,
   parameter int GEN_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      load_valid,
   output logic                      load_ready,
   input  logic [WIDTH-1:0]          load_row,
   input  logic                      step_start,
   input  logic [GEN_W-1:0]          step_count,
   output logic                      busy,
   output logic [WIDTH*HEIGHT-1:0]   cur_states,
   input  logic [WIDTH*HEIGHT-1:0]   next_states,
   input  logic                      rd_start,
   output logic                      rd_valid,
   input  logic                      rd_ready,
   output logic [WIDTH-1:0]          rd_row,
   output logic                      rd_last,
   output logic [GEN_W-1:0]          generation,
   output logic                      stable
);

   localparam int CELLS = WIDTH * HEIGHT;
   localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;

   state_t             state_q, state_d;
   logic [CELLS-1:0]   board;
   logic [IDX_W-1:0]   idx;
   logic [GEN_W-1:0]   remaining;

   logic idx_last, load_fire, step_go, dump_go, rd_fire, still, run_last;

   // IDLE start priority: load beat, then step request, then dump request.
   assign idx_last  = (idx == IDX_W'(HEIGHT - 1));
   assign load_fire = load_valid && load_ready;
   assign step_go   = (state_q == IDLE) && !load_valid && step_start && (step_count != '0);
   assign dump_go   = (state_q == IDLE) && !load_valid && !step_start && rd_start;
   assign rd_fire   = (state_q == DUMP) && rd_ready;
   assign run_last  = (state_q == RUN) && ((remaining == GEN_W'(1)) || still);

   assign load_ready = (state_q == IDLE) || (state_q == LOAD);
   assign busy       = (state_q != IDLE);
   assign rd_valid   = (state_q == DUMP);
   assign rd_last    = rd_valid && idx_last;
   assign rd_row     = board[int'(idx)*WIDTH +: WIDTH];
   assign cur_states = board;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load_fire)    state_d = idx_last ? IDLE : LOAD;
            else if (step_go) state_d = RUN;
            else if (dump_go) state_d = DUMP;
         end
         LOAD:    if (load_fire && idx_last) state_d = IDLE;
         RUN:     if (run_last)              state_d = IDLE;
         DUMP:    if (rd_fire && idx_last)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the board is a plain flop vector, so it is cleared by reset like any other state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         board      <= '0;
         idx        <= '0;
         remaining  <= '0;
         generation <= '0;
      end else if (load_fire) begin
         // NOTE: non-blocking so the row write uses the pre-increment idx.
         board[int'(idx)*WIDTH +: WIDTH] <= load_row;
         if (idx_last) begin
            idx        <= '0;
            generation <= '0;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end else if (step_go) begin
         remaining <= step_count;
      end else if (dump_go) begin
         idx <= '0;
      end else if (state_q == RUN) begin
         board      <= next_states;
         generation <= generation + GEN_W'(1);
         remaining  <= remaining - GEN_W'(1);
      end else if (rd_fire) begin
         idx <= idx_last ? '0 : idx + IDX_W'(1);
      end
   end

`ifdef CONWAY_STILL_STOP_EN
   assign still = (next_states == board);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        stable <= 1'b0;
      else if (load_fire || step_go)     stable <= 1'b0;
      else if ((state_q == RUN) && still) stable <= 1'b1;
   end
`else
   assign still  = 1'b0;
   assign stable = 1'b0;
`endif

endmodule
